// File: rtl/sram16_mem_ctrl.sv
// ---------------------------------------------------------------------------
// sram16_mem_ctrl
//
// Memory-side responder for the core's data/instruction port. Serves byte,
// half and word accesses from an external asynchronous 16-bit SRAM. A word is
// split into two half accesses (PH0 = low half, PH1 = high half) and every half
// access is stretched to WAIT+1 cycles. mem_busy stalls the core until the
// result is ready; illegal requests are rejected in a single cycle.
//
// The cycle in which IDLE accepts a request already drives the SRAM and counts
// as the first cycle of PH0. A byte/half access therefore completes in WAIT+2
// cycles and a word in 2*WAIT+3 cycles, both including the completing cycle.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   mem_r, mem_w    read / write request levels
//   fetch           instruction fetch, behaves as a read
//   mem_sz          0 byte, 1 half, 2 word, 3 illegal
//   mem_addr        byte address (bits above ADDR_W are ignored)
//   mem_wdata       right-justified write data
//   mem_rdata       registered, right-justified, zero-extended read data
//   mem_busy        combinational stall
//   mem_err         one-cycle pulse on a rejected request
//   ext_cs/oe/we    SRAM select, output enable, write enable
//   ext_be          byte lane enables (bit0 = [7:0], bit1 = [15:8])
//   ext_addr        SRAM halfword address
//   ext_dout        write data to the SRAM
//   ext_din         read data from the SRAM
// ---------------------------------------------------------------------------
module sram16_mem_ctrl #(
   parameter int ADDR_W = 18,
   parameter int WAIT   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_r,
   input  logic              mem_w,
   input  logic              fetch,
   input  logic [1:0]        mem_sz,
   input  logic [31:0]       mem_addr,
   input  logic [31:0]       mem_wdata,
   output logic [31:0]       mem_rdata,
   output logic              mem_busy,
   output logic              mem_err,
   output logic              ext_cs,
   output logic              ext_oe,
   output logic              ext_we,
   output logic [1:0]        ext_be,
   output logic [ADDR_W-1:0] ext_addr,
   output logic [15:0]       ext_dout,
   input  logic [15:0]       ext_din
);

   typedef enum logic [1:0] {IDLE, PH0, PH1, DONE} state_t;

   localparam logic [1:0] SZ_BYTE  = 2'd0;
   localparam logic [1:0] SZ_HALF  = 2'd1;
   localparam logic [1:0] SZ_WORD  = 2'd2;
   localparam logic [1:0] SZ_BAD   = 2'd3;
   localparam logic [3:0] WAIT_CNT = 4'(WAIT);

   state_t            state, state_nxt;
   logic [3:0]        cnt, cnt_nxt;

   // Transaction latched on acceptance
   logic [ADDR_W-1:0] haddr_q;
   logic              b0_q;
   logic [1:0]        sz_q;
   logic [31:0]       wdata_q;
   logic              dir_w_q;

   logic [15:0]       lo_q;         // PH0 read data of a word
   logic [31:0]       rdata_q;
   logic [ADDR_W-1:0] ext_addr_q;   // last driven SRAM address
   logic [15:0]       ext_dout_q;   // last driven SRAM write data

   logic              req, idle, in_ph1, bad, reject, accept, active;
   logic              last, final_ph;
   logic [ADDR_W-1:0] cur_haddr, addr_drv;
   logic              cur_b0, cur_w;
   logic [1:0]        cur_sz, be_drv;
   logic [31:0]       cur_wdata;
   logic [3:0]        cur_cnt;
   logic [15:0]       dout_drv, rd_half;
   logic              unused_ok;

   assign req    = mem_r | fetch | mem_w;
   assign idle   = (state == IDLE);
   assign in_ph1 = (state == PH1);

   assign bad    = (mem_sz == SZ_BAD)
                 | ((mem_sz == SZ_HALF) & mem_addr[0])
                 | ((mem_sz == SZ_WORD) & (mem_addr[1:0] != 2'b00))
                 | (mem_w & (mem_r | fetch));
   assign reject = idle & req & bad;
   assign accept = idle & req & ~bad & ~rst;

   // Strobes drop in the same cycle the core withdraws its request.
   assign active = accept | (((state == PH0) | in_ph1) & req);

   // While accepting, the live request is the transaction; afterwards the
   // latched copy is.
   assign cur_haddr = idle ? mem_addr[ADDR_W:1] : haddr_q;
   assign cur_b0    = idle ? mem_addr[0]        : b0_q;
   assign cur_sz    = idle ? mem_sz             : sz_q;
   assign cur_wdata = idle ? mem_wdata          : wdata_q;
   assign cur_w     = idle ? mem_w              : dir_w_q;
   assign cur_cnt   = idle ? WAIT_CNT           : cnt;

   assign last     = active & (cur_cnt == 4'd0);
   assign final_ph = (cur_sz != SZ_WORD) | in_ph1;

   assign addr_drv = in_ph1 ? cur_haddr + ADDR_W'(1) : cur_haddr;
   assign be_drv   = (cur_sz == SZ_BYTE) ? (cur_b0 ? 2'b10 : 2'b01) : 2'b11;
   assign dout_drv = (cur_sz == SZ_BYTE) ? {2{cur_wdata[7:0]}}
                   : (in_ph1 ? cur_wdata[31:16] : cur_wdata[15:0]);
   assign rd_half  = (cur_sz == SZ_BYTE)
                   ? {8'h00, (cur_b0 ? ext_din[15:8] : ext_din[7:0])}
                   : ext_din;

   assign ext_cs   = active;
   assign ext_oe   = active & ~cur_w;
   assign ext_we   = active & cur_w;
   assign ext_be   = active ? be_drv   : 2'b00;
   assign ext_addr = active ? addr_drv : ext_addr_q;
   assign ext_dout = active ? dout_drv : ext_dout_q;

   assign mem_err   = reject & ~rst;
   assign mem_busy  = req & (state != DONE) & ~reject;
   assign mem_rdata = mem_err ? 32'h0 : rdata_q;

   // Address bits above the physical space alias and are deliberately dropped.
   assign unused_ok = &{1'b0, mem_addr[31:ADDR_W+1]};

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a value unassigned and no latch is inferred.
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE, PH0: begin
            if (idle ? accept : req) begin
               if (last) begin
                  state_nxt = (cur_sz == SZ_WORD) ? PH1 : DONE;
                  cnt_nxt   = WAIT_CNT;
               end else begin
                  state_nxt = PH0;
                  cnt_nxt   = cur_cnt - 4'd1;
               end
            end else if (!idle) begin
               state_nxt = IDLE;             // abort: request withdrawn
            end
         end
         PH1: begin
            if (!req)      state_nxt = IDLE;
            else if (last) state_nxt = DONE;
            else           cnt_nxt   = cnt - 4'd1;
         end
         default: state_nxt = IDLE;          // DONE
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         haddr_q    <= '0;
         b0_q       <= 1'b0;
         sz_q       <= 2'b00;
         wdata_q    <= 32'h0;
         dir_w_q    <= 1'b0;
         lo_q       <= 16'h0;
         rdata_q    <= 32'h0;
         ext_addr_q <= '0;
         ext_dout_q <= 16'h0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            haddr_q <= mem_addr[ADDR_W:1];
            b0_q    <= mem_addr[0];
            sz_q    <= mem_sz;
            wdata_q <= mem_wdata;
            dir_w_q <= mem_w;
         end
         if (active) begin
            ext_addr_q <= addr_drv;
            ext_dout_q <= dout_drv;
         end
         // Read lanes are captured in the last cycle of each phase; the result
         // register only changes when a transaction actually completes.
         if (reject) begin
            rdata_q <= 32'h0;
         end else if (last) begin
            if (!final_ph)               lo_q    <= ext_din;
            else if (cur_w)              rdata_q <= 32'h0;
            else if (cur_sz == SZ_WORD)  rdata_q <= {ext_din, lo_q};
            else                         rdata_q <= {16'h0, rd_half};
         end
      end
   end

endmodule

// File: tb/tb_sram16_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram16_mem_ctrl
//
// Two controllers (WAIT=1 and WAIT=2), each attached to its own behavioural
// SRAM. A byte-addressed reference memory predicts read data, latency and the
// SRAM contents after writes. Directed scenarios are followed by randomized
// transactions.
// ---------------------------------------------------------------------------
module tb_sram16_mem_ctrl;

   localparam int AW = 10;
   localparam int NH = 1 << AW;        // halfwords per SRAM
   localparam int NB = 1 << (AW + 1);  // bytes per SRAM

   typedef struct {
      int           cycles;
      int           strobe_cycles;
      logic         err;
      logic [31:0]  rdata;
      logic [AW-1:0] addr0;
      logic [AW-1:0] addr1;
      logic [1:0]   be0;
      logic [15:0]  dout0;
      logic         oe;
      logic         we;
   } obs_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          sram_clr;
   logic          mem_r[2], mem_w[2], fetch[2];
   logic [1:0]    mem_sz[2];
   logic [31:0]   mem_addr[2], mem_wdata[2], mem_rdata[2];
   logic          mem_busy[2], mem_err[2], ext_cs[2], ext_oe[2], ext_we[2];
   logic [1:0]    ext_be[2];
   logic [AW-1:0] ext_addr[2];
   logic [15:0]   ext_dout[2], ext_din[2];
   logic [15:0]   sram[2][NH];
   logic [7:0]    ref_mem[2][NB];
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;

   for (genvar k = 0; k < 2; k++) begin : g_dut
      sram16_mem_ctrl #(.ADDR_W(AW), .WAIT(k + 1)) dut (
         .clk(clk), .rst(rst),
         .mem_r(mem_r[k]), .mem_w(mem_w[k]), .fetch(fetch[k]),
         .mem_sz(mem_sz[k]), .mem_addr(mem_addr[k]), .mem_wdata(mem_wdata[k]),
         .mem_rdata(mem_rdata[k]), .mem_busy(mem_busy[k]), .mem_err(mem_err[k]),
         .ext_cs(ext_cs[k]), .ext_oe(ext_oe[k]), .ext_we(ext_we[k]),
         .ext_be(ext_be[k]), .ext_addr(ext_addr[k]), .ext_dout(ext_dout[k]),
         .ext_din(ext_din[k])
      );
   end

   // Behavioural asynchronous SRAMs
   always_comb
      for (int k = 0; k < 2; k++) ext_din[k] = sram[k][ext_addr[k]];

   always @(posedge clk) begin
      if (sram_clr) begin
         for (int k = 0; k < 2; k++)
            for (int h = 0; h < NH; h++) sram[k][h] <= 16'h0;
      end else begin
         for (int k = 0; k < 2; k++)
            if (ext_cs[k] && ext_we[k]) begin
               if (ext_be[k][0]) sram[k][ext_addr[k]][7:0]  <= ext_dout[k][7:0];
               if (ext_be[k][1]) sram[k][ext_addr[k]][15:8] <= ext_dout[k][15:8];
            end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test, expected completion");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs(input int k);
      mem_r[k] = 1'b0; mem_w[k] = 1'b0; fetch[k] = 1'b0;
      mem_sz[k] = 2'b00; mem_addr[k] = 32'h0; mem_wdata[k] = 32'h0;
   endtask

   // Called at posedge+1; holds the request until mem_busy is low, returns
   // at posedge+1 after the completing cycle with the request withdrawn.
   task automatic drive(input int k, input logic r, input logic w, input logic f,
                        input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, output obs_t o);
      bit done = 0;
      mem_r[k] = r; mem_w[k] = w; fetch[k] = f;
      mem_sz[k] = sz; mem_addr[k] = a; mem_wdata[k] = wd;
      o.cycles = 0; o.strobe_cycles = 0; o.err = 1'b0; o.rdata = 32'h0;
      o.addr0 = '0; o.addr1 = '0; o.be0 = 2'b00; o.dout0 = 16'h0;
      o.oe = 1'b0; o.we = 1'b0;
      for (int c = 0; c < 100 && !done; c++) begin
         @(negedge clk);
         o.cycles++;
         if (ext_cs[k]) begin
            if (o.strobe_cycles == 0) begin
               o.addr0 = ext_addr[k]; o.be0 = ext_be[k]; o.dout0 = ext_dout[k];
            end
            o.addr1 = ext_addr[k];
            o.strobe_cycles++;
            o.oe |= ext_oe[k];
            o.we |= ext_we[k];
         end
         if (!mem_busy[k]) begin
            o.err = mem_err[k];
            o.rdata = mem_rdata[k];
            done = 1;
         end else begin
            @(posedge clk); #1;
         end
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL timeout: got busy after 100 cycles, expected completion");
      end
      @(posedge clk); #1;
      idle_inputs(k);
   endtask

   // Predicts the transaction from the reference memory, runs it and compares.
   task automatic run(input int k, input logic r, input logic w, input logic f,
                      input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, input string tag, output obs_t o);
      logic        rej;
      logic [31:0] exp_rd;
      int          exp_cyc, base, nb, ws, h;
      ws      = k + 1;
      rej     = (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
                (sz == 2'd2 && a[1:0] != 2'b00) || (w && (r || f));
      base    = int'(a & 32'(NB - 1));
      nb      = 1 << sz;
      exp_rd  = 32'h0;
      exp_cyc = rej ? 1 : ((sz == 2'd2) ? 2 * ws + 3 : ws + 2);
      if (!rej && !w)
         for (int i = 0; i < nb; i++) exp_rd[8*i +: 8] = ref_mem[k][base + i];
      if (!rej && w)
         for (int i = 0; i < nb; i++) ref_mem[k][base + i] = wd[8*i +: 8];
      drive(k, r, w, f, sz, a, wd, o);
      check({tag, ".cycles"}, 32'(o.cycles), 32'(exp_cyc));
      check({tag, ".err"}, 32'(o.err), 32'(rej));
      check({tag, ".rdata"}, o.rdata, exp_rd);
      check({tag, ".strobes"}, 32'(o.strobe_cycles), rej ? 32'h0 : 32'(exp_cyc - 1));
      check({tag, ".we"}, 32'(o.we), 32'(!rej && w));
      check({tag, ".oe"}, 32'(o.oe), 32'(!rej && !w));
      if (!rej && w)
         for (int j = 0; j < ((sz == 2'd2) ? 2 : 1); j++) begin
            h = (base >> 1) + j;
            check({tag, ".mem"}, 32'(sram[k][h]),
                  32'({ref_mem[k][2*h + 1], ref_mem[k][2*h]}));
         end
   endtask

   initial begin
      obs_t          o;
      logic          r, w, f;
      logic [1:0]    sz;
      logic [31:0]   a;
      int            op, nbad;

      for (int k = 0; k < 2; k++) begin
         idle_inputs(k);
         for (int i = 0; i < NB; i++) ref_mem[k][i] = 8'h00;
      end
      rst = 1'b1; sram_clr = 1'b1;
      repeat (3) @(posedge clk);
      #1; rst = 1'b0; sram_clr = 1'b0;

      // Reset state
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check("rst.rdata", mem_rdata[k], 32'h0);
         check("rst.err", 32'(mem_err[k]), 32'h0);
         check("rst.busy", 32'(mem_busy[k]), 32'h0);
         check("rst.cs", 32'(ext_cs[k]), 32'h0);
         check("rst.be", 32'(ext_be[k]), 32'h0);
         check("rst.addr", 32'(ext_addr[k]), 32'h0);
         check("rst.dout", 32'(ext_dout[k]), 32'h0);
      end
      @(posedge clk); #1;

      // WAIT=1 byte write to the odd lane
      run(0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0000_0103, 32'h00FF_FFAB, "bytewr", o);
      check("bytewr.addr", 32'(o.addr0), 32'h81);
      check("bytewr.be", 32'(o.be0), 32'h2);
      check("bytewr.dout", 32'(o.dout0), 32'hABAB);
      check("bytewr.cyc3", 32'(o.cycles), 32'd3);
      check("bytewr.half", 32'(sram[0][10'h81]), 32'hAB00);

      // WAIT=1 word write then word read at 0x200
      run(0, 1'b0, 1'b1, 1'b0, 2'd2, 32'h0000_0200, 32'h5678_1234, "wordwr", o);
      run(0, 1'b1, 1'b0, 1'b0, 2'd2, 32'h0000_0200, 32'h0, "wordrd", o);
      check("wordrd.addr0", 32'(o.addr0), 32'h100);
      check("wordrd.addr1", 32'(o.addr1), 32'h101);
      check("wordrd.val", o.rdata, 32'h5678_1234);
      check("wordrd.cyc5", 32'(o.cycles), 32'd5);

      // Rejections (rdata is non-zero beforehand)
      run(0, 1'b1, 1'b0, 1'b0, 2'd2, 32'h0000_0002, 32'h0, "rej.misal", o);
      run(0, 1'b1, 1'b0, 1'b0, 2'd3, 32'h0000_0000, 32'h0, "rej.sz3", o);
      run(0, 1'b1, 1'b1, 1'b0, 2'd0, 32'h0000_0004, 32'h55, "rej.rw", o);
      run(0, 1'b0, 1'b0, 1'b1, 2'd1, 32'h0000_0011, 32'h0, "rej.half", o);

      // WAIT=2: fetch half back-to-back with a word write
      run(1, 1'b0, 1'b1, 1'b0, 2'd1, 32'h0000_0010, 32'h0000_BEEF, "pre", o);
      run(1, 1'b0, 1'b0, 1'b1, 2'd1, 32'h0000_0010, 32'h0, "fetch", o);
      check("fetch.cyc4", 32'(o.cycles), 32'd4);
      run(1, 1'b0, 1'b1, 1'b0, 2'd2, 32'h0000_0020, 32'hA5C3_0FF1, "b2bwr", o);
      check("b2bwr.cyc7", 32'(o.cycles), 32'd7);

      // Reset in the 2nd cycle of PH1 of a word write (WAIT=2)
      mem_w[1] = 1'b1; mem_sz[1] = 2'd2;
      mem_addr[1] = 32'h0000_0040; mem_wdata[1] = 32'hCAFE_F00D;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rstph1.cs", 32'(ext_cs[1]), 32'h1);
      check("rstph1.addr", 32'(ext_addr[1]), 32'h21);
      @(posedge clk); #1;
      rst = 1'b1; idle_inputs(1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rstph1.cs_off", 32'(ext_cs[1]), 32'h0);
      check("rstph1.we_off", 32'(ext_we[1]), 32'h0);
      check("rstph1.be_off", 32'(ext_be[1]), 32'h0);
      check("rstph1.busy", 32'(mem_busy[1]), 32'h0);
      check("rstph1.rdata", mem_rdata[1], 32'h0);
      // The interrupted write leaves SRAM in an environment-defined state.
      for (int i = 0; i < 4; i++)
         ref_mem[1][32'h40 + i] = sram[1][(32'h40 + i) >> 1][8*(i % 2) +: 8];
      @(posedge clk); #1;
      run(1, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0000_0011, 32'h0, "postrst", o);
      check("postrst.val", o.rdata, 32'h0000_00BE);

      // Abort mid-PH0 of a word read (WAIT=2)
      run(1, 1'b1, 1'b0, 1'b0, 2'd1, 32'h0000_0010, 32'h0, "prevrd", o);
      mem_r[1] = 1'b1; mem_sz[1] = 2'd2; mem_addr[1] = 32'h0000_0020;
      @(posedge clk); #1;
      idle_inputs(1);
      @(negedge clk);
      check("abort.err0", 32'(mem_err[1]), 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      check("abort.cs", 32'(ext_cs[1]), 32'h0);
      check("abort.oe", 32'(ext_oe[1]), 32'h0);
      check("abort.err", 32'(mem_err[1]), 32'h0);
      check("abort.rdata", mem_rdata[1], 32'h0000_BEEF);
      @(posedge clk); #1;
      run(1, 1'b1, 1'b0, 1'b0, 2'd2, 32'h0000_0020, 32'h0, "afterabort", o);
      check("afterabort.val", o.rdata, 32'hA5C3_0FF1);

      // Randomized traffic on both controllers
      for (int k = 0; k < 2; k++)
         for (int n = 0; n < 60; n++) begin
            op = $urandom_range(0, 5);
            r  = (op <= 1) || (op == 5);
            f  = (op == 2);
            w  = (op >= 3);
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = $urandom;
            if ($urandom_range(0, 4) != 0)
               a = (sz == 2'd2) ? (a & ~32'h3) : ((sz == 2'd1) ? (a & ~32'h1) : a);
            run(k, r, w, f, sz, a, $urandom, "rand", o);
            if ($urandom_range(0, 2) == 0) begin
               @(posedge clk); #1;
            end
         end

      // Whole-memory comparison against the reference
      for (int k = 0; k < 2; k++) begin
         nbad = 0;
         for (int h = 0; h < NH; h++)
            if (sram[k][h] !== {ref_mem[k][2*h + 1], ref_mem[k][2*h]}) nbad++;
         check("sweep", 32'(nbad), 32'h0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram16_mem_ctrl.md
Name: sram16_mem_ctrl

Overview:
- Memory-side responder for the core's data/instruction memory port: mem_r/mem_w/fetch/mem_sz/mem_addr/mem_wdata in; mem_rdata/mem_busy out.
- Serves byte, half and word accesses from an external asynchronous 16-bit SRAM.
- Words are split into two half accesses. Each half access is stretched by programmable wait states.
- Holds the core with mem_busy until the result is ready.

Parameters:
- ADDR_W, 18: external halfword address width. Physical space is 2^(ADDR_W+1) bytes; upper mem_addr bits are ignored (aliasing).
- WAIT, 1: extra cycles per half access, 0..15. Each phase lasts WAIT+1 cycles.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- mem_r  in  1  read request (level)
- mem_w  in  1  write request (level)
- fetch  in  1  instruction fetch qualifier; behaves as a read
- mem_sz  in  2  0=byte, 1=half, 2=word, 3=illegal
- mem_addr  in  32  byte address
- mem_wdata  in  32  write data, right-justified
- mem_rdata  out  32  read data, right-justified, zero-extended
- mem_busy  out  1  stall core
- mem_err  out  1  one-cycle pulse on a rejected request
- ext_cs  out  1  SRAM select
- ext_oe  out  1  SRAM output enable (read)
- ext_we  out  1  SRAM write enable
- ext_be  out  2  byte lane enables; bit0 = [7:0], bit1 = [15:8]
- ext_addr  out  ADDR_W  halfword address
- ext_dout  out  16  write data to SRAM
- ext_din  in  16  read data from SRAM

Behaviour:
- Request definition: req = (mem_r | fetch | mem_w).
- Handshake:
  - Core holds a request stable while mem_busy=1.
  - Any cycle with req=1 and mem_busy=0 completes one transaction.
  - A new req in the next cycle is a new transaction.
- mem_busy = req & (state != DONE) & !reject. It is combinational, so it rises in the first cycle a request appears.
- Reject conditions (checked combinationally in IDLE):
  - mem_sz=3
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - mem_w together with mem_r or fetch
- On reject: mem_busy=0 and mem_err=1 in that same cycle, mem_rdata=0, no external strobe. The transaction is completed.
- States: IDLE, PH0, PH1, DONE.
  - IDLE: on an accepted req, latch sz, addr, wdata and dir, then go to PH0 with wait counter = WAIT.
  - PH0: drive the first half. Decrement the counter each cycle. When the counter reaches 0, capture read lanes, then go to PH1 if word, else DONE.
  - PH1: second half at ext_addr+1, counter reloaded to WAIT. Same counting, then DONE.
  - DONE: mem_busy=0, mem_rdata valid. Next state is IDLE.
- Latency, counted from the first req cycle to the completing cycle inclusive:
  - byte/half: WAIT+2 cycles (busy for WAIT+1)
  - word: 2*WAIT+3 cycles
- External drive during PH0 and PH1:
  - ext_cs=1; ext_oe=!dir_w; ext_we=dir_w.
  - ext_addr = latched addr[ADDR_W:1], plus 1 in PH1.
  - In IDLE and DONE all strobes are 0; ext_addr and ext_dout hold their last values.
- Lanes:
  - byte: be = addr[0] ? 2'b10 : 2'b01; ext_dout = {wdata[7:0], wdata[7:0]}.
  - half/word: be = 2'b11. PH0 carries wdata[15:0]; PH1 carries wdata[31:16].
- Read assembly:
  - byte: {24'b0, selected lane}
  - half: {16'b0, din}
  - word: {PH1 din, PH0 din}
  - ext_din is sampled in the last cycle of each phase.
- mem_rdata is registered and holds its value until the next completion. It is 0 after a write completion.
- Abort: if req drops while in PH0 or PH1, go to IDLE next cycle and deassert strobes. There is no completion and no err.
- Reset:
  - Synchronous. State IDLE and strobes 0 in the cycle after rst, including mid-transaction.
  - Reset values: mem_rdata=0, mem_err=0, ext_addr=0, ext_dout=0, ext_be=0.
  - mem_busy follows req while state=IDLE after reset.
- WAIT=0: each phase is 1 cycle; a word takes 3 cycles total.

Test Plan:
- WAIT=1, mem_w, sz=0, addr=0x0000_0103, wdata=0xFF_FFAB:
  - ext_addr=0x81, be=2'b10, dout=0xABAB, we=1 for 2 cycles.
  - busy 2 cycles, completes in cycle 3.
  - Model byte 0x103 = 0xAB; byte 0x102 unchanged.
- WAIT=1, mem_r, sz=2, addr=0x200; model half 0x100=0x1234, half 0x101=0x5678:
  - ext_addr 0x100 then 0x101, oe=1.
  - busy 4 cycles, mem_rdata=0x5678_1234 on cycle 5.
- mem_r, sz=2, addr=0x2 (misaligned); then sz=3:
  - busy=0, mem_err=1 in the same cycle, rdata=0, cs never asserted.
- WAIT=2: fetch half at 0x10 back-to-back with a write word at 0x20:
  - first completes in cycle 4.
  - second starts the next cycle and completes after 7 more cycles.
  - Model contents correct.
- rst asserted in the 2nd cycle of PH1 of a word write:
  - strobes 0 the next cycle, state IDLE.
  - A following byte read completes normally with correct data.
- req dropped mid-PH0 of a word read:
  - strobes 0 the next cycle, no err.
  - mem_rdata retains its previous value.
